// File: rtl/seq_pkg.sv
// Shared types and defaults for the multi-cycle instruction sequencer.
package seq_pkg;

    localparam logic [2:0] HALT_OP_DEF = 3'b111;
    localparam int         TMO_W_DEF   = 4;
    localparam int         CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        FAULT  = 3'd7
    } seq_state_t;

    // One bit per sequencer output; registered as a unit so all strobes
    // change together on the clock edge.
    typedef struct packed {
        logic ir_load;
        logic pc_en;
        logic pc_sel;
        logic reg_wr_en;
        logic mem_req;
        logic mem_we;
        logic busy;
        logic done;
        logic fault;
    } seq_out_t;

    // Moore decode of a state plus the per-instruction latched qualifiers.
    function automatic seq_out_t decode_outputs(
        input seq_state_t st,
        input logic       taken,
        input logic       we,
        input logic       rw
    );
        seq_out_t o;
        o = '{default: 1'b0};
        case (st)
            FETCH: begin
                o.ir_load = 1'b1;
                o.busy    = 1'b1;
            end
            DECODE, EXEC: begin
                o.busy = 1'b1;
            end
            MEM: begin
                o.mem_req = 1'b1;
                o.mem_we  = we;
                o.busy    = 1'b1;
            end
            WB: begin
                o.pc_en     = 1'b1;
                o.pc_sel    = taken;
                o.reg_wr_en = rw;
                o.busy      = 1'b1;
            end
            HALT: begin
                o.done = 1'b1;
            end
            FAULT: begin
                o.fault = 1'b1;
            end
            default: begin
                o = '{default: 1'b0};
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating counter of memory-wait cycles; flags the cycle that would
// complete the last allowed wait.
module mem_wait_timer #(
    parameter int TMO_W = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam logic [TMO_W-1:0] CNT_MAX  = {TMO_W{1'b1}};
    localparam logic [TMO_W-1:0] CNT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count enabled cycles up to saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {TMO_W{1'b0}};
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= {TMO_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal when this enabled cycle is the (2**TMO_W-1)-th wait.
    assign terminal_o = enable_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout,
// halt detection and retired-instruction counting.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int               OPW     = 3,
    parameter logic [OPW-1:0]   HALT_OP = HALT_OP_DEF,
    parameter int               TMO_W   = TMO_W_DEF,
    parameter int               CNT_W   = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [OPW-1:0]   Opcode,
    input  logic             RegWrite,
    input  logic             MemWrite,
    input  logic             MemtoReg,
    input  logic             Branch,
    input  logic             BranchTaken,
    input  logic             MemAck,
    output logic             IRLoad,
    output logic             PCEn,
    output logic             PCSel,
    output logic             RegWrEn,
    output logic             MemReq,
    output logic             MemWe,
    output logic             Busy,
    output logic             Done,
    output logic             Fault,
    output logic [CNT_W-1:0] InstrCount
);

    seq_state_t       state_q, state_d;
    logic             taken_q, taken_d;
    logic             we_q, we_d;
    logic             rw_q, rw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    seq_out_t         out_q, out_d;

    logic             tmr_clear_s;
    logic             tmr_enable_s;
    logic             tmr_terminal_s;
    logic             resting_s;

    // The timer only runs inside MEM; any other state holds it at zero,
    // which also gives the clear-on-entry behaviour.
    assign tmr_clear_s  = (state_q != MEM);
    assign tmr_enable_s = (state_q == MEM) && !MemAck;
    assign resting_s    = (state_q == IDLE) || (state_q == HALT) || (state_q == FAULT);

    mem_wait_timer #(
        .TMO_W (TMO_W)
    ) u_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .clear_i    (tmr_clear_s),
        .enable_i   (tmr_enable_s),
        .terminal_o (tmr_terminal_s)
    );

    // Next-state logic of the sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HALT, FAULT: begin
                if (Start) begin
                    state_d = FETCH;
                end else begin
                    state_d = state_q;
                end
            end
            FETCH: begin
                state_d = DECODE;
            end
            DECODE: begin
                if (Opcode == HALT_OP) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (MemWrite || MemtoReg) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                // An ack beats the terminal count in the same cycle.
                if (MemAck) begin
                    state_d = WB;
                end else if (tmr_terminal_s) begin
                    state_d = FAULT;
                end else begin
                    state_d = MEM;
                end
            end
            WB: begin
                state_d = FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-instruction qualifiers captured in EXEC so MEM/WB strobes stay
    // steady regardless of later flag activity. Both-store-and-load acts
    // as a store because MemWe follows MemWrite directly.
    always_comb begin
        taken_d = taken_q;
        we_d    = we_q;
        rw_d    = rw_q;
        if (state_q == EXEC) begin
            taken_d = Branch & BranchTaken;
            we_d    = MemWrite;
            rw_d    = RegWrite & ~MemWrite;
        end else begin
            taken_d = taken_q;
            we_d    = we_q;
            rw_d    = rw_q;
        end
    end

    // Retired-instruction counter: cleared on restart, bumped in WB.
    always_comb begin
        cnt_d = cnt_q;
        if (resting_s && Start) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (state_q == WB) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs are decoded from the next state and registered, so they are
    // glitch-free and line up exactly with the state they belong to.
    always_comb begin
        out_d = decode_outputs(state_d, taken_d, we_d, rw_d);
    end

    // State, latches, counter and output registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            taken_q <= 1'b0;
            we_q    <= 1'b0;
            rw_q    <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            out_q   <= '{default: 1'b0};
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
            we_q    <= we_d;
            rw_q    <= rw_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign IRLoad     = out_q.ir_load;
    assign PCEn       = out_q.pc_en;
    assign PCSel      = out_q.pc_sel;
    assign RegWrEn    = out_q.reg_wr_en;
    assign MemReq     = out_q.mem_req;
    assign MemWe      = out_q.mem_we;
    assign Busy       = out_q.busy;
    assign Done       = out_q.done;
    assign Fault      = out_q.fault;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: a per-instruction cycle model predicts every output
// each cycle; a second narrow-counter instance exercises counter wrap.
module tb_instr_sequencer;
    import seq_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  Opcode;
    logic        RegWrite, MemWrite, MemtoReg, Branch, BranchTaken, MemAck;
    logic        IRLoad, PCEn, PCSel, RegWrEn, MemReq, MemWe, Busy, Done, Fault;
    logic [15:0] InstrCount;

    logic        w_ir, w_pce, w_pcs, w_rwe, w_mreq, w_mwe, w_busy, w_done, w_fault;
    logic [3:0]  cnt4;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 Clk = ~Clk;

    instr_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Opcode(Opcode),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .Branch(Branch), .BranchTaken(BranchTaken), .MemAck(MemAck),
        .IRLoad(IRLoad), .PCEn(PCEn), .PCSel(PCSel), .RegWrEn(RegWrEn),
        .MemReq(MemReq), .MemWe(MemWe), .Busy(Busy), .Done(Done),
        .Fault(Fault), .InstrCount(InstrCount)
    );

    instr_sequencer #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Opcode(Opcode),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .Branch(Branch), .BranchTaken(BranchTaken), .MemAck(MemAck),
        .IRLoad(w_ir), .PCEn(w_pce), .PCSel(w_pcs), .RegWrEn(w_rwe),
        .MemReq(w_mreq), .MemWe(w_mwe), .Busy(w_busy), .Done(w_done),
        .Fault(w_fault), .InstrCount(cnt4)
    );

    function automatic logic [8:0] mk(input bit ir, pce, pcs, rwe, mreq, mwe, busy, done, fault);
        return {ir, pce, pcs, rwe, mreq, mwe, busy, done, fault};
    endfunction

    function automatic logic [8:0] obs();
        return {IRLoad, PCEn, PCSel, RegWrEn, MemReq, MemWe, Busy, Done, Fault};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock cycle: inputs already driven; compare at the falling edge.
    task automatic cyc(input logic [8:0] e, input string tag);
        logic [31:0] c;
        @(negedge Clk);
        c = exp_cnt;
        chk({tag, ":outs"}, {23'd0, obs()}, {23'd0, e});
        chk({tag, ":cnt"},  {16'd0, InstrCount}, {16'd0, c[15:0]});
        chk({tag, ":cnt4"}, {28'd0, cnt4}, {28'd0, c[3:0]});
        @(posedge Clk);
        #1;
    endtask

    // A cycle spent in IDLE/HALT/FAULT.
    task automatic rest_cycle(input bit done, input bit fault, input bit start, input string tag);
        Start  = start;
        MemAck = 1'($urandom_range(0, 1));
        cyc(mk(0, 0, 0, 0, 0, 0, 0, done, fault), tag);
        if (start) exp_cnt = 0;
        Start = 1'b0;
    endtask

    // Runs one instruction from its FETCH cycle. ackdly = index of the MEM
    // cycle carrying the ack; 15 or more means no ack. res: 0 retired,
    // 1 halted, 2 faulted.
    task automatic run_instr(input logic [2:0] op, input bit rw, mw, mr, br, bt,
                             input int ackdly, output int res, input string tag);
        bit acked;
        Opcode = op; RegWrite = rw; MemWrite = mw; MemtoReg = mr;
        Branch = br; BranchTaken = bt;
        Start = 1'($urandom_range(0, 1)); MemAck = 1'($urandom_range(0, 1));
        cyc(mk(1, 0, 0, 0, 0, 0, 1, 0, 0), {tag, ":fetch"});
        Start = 1'($urandom_range(0, 1)); MemAck = 1'($urandom_range(0, 1));
        cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), {tag, ":decode"});
        if (op == 3'b111) begin
            res = 1;
            Start = 1'b0;
            return;
        end
        Start = 1'($urandom_range(0, 1)); MemAck = 1'($urandom_range(0, 1));
        cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), {tag, ":exec"});
        if (mw || mr) begin
            acked = 1'b0;
            for (int k = 0; k < 15; k++) begin
                Start  = 1'($urandom_range(0, 1));
                MemAck = (k == ackdly);
                cyc(mk(0, 0, 0, 0, 1, mw, 1, 0, 0), {tag, ":mem"});
                if (k == ackdly) begin
                    acked = 1'b1;
                    break;
                end
            end
            if (!acked) begin
                res = 2;
                Start = 1'b0;
                return;
            end
        end
        Start = 1'($urandom_range(0, 1)); MemAck = 1'($urandom_range(0, 1));
        cyc(mk(0, 1, br & bt, rw & ~mw, 0, 0, 1, 0, 0), {tag, ":wb"});
        exp_cnt++;
        res = 0;
        Start = 1'b0;
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int res;
        logic [2:0] op;
        Reset = 1'b0; Start = 1'b0; Opcode = 3'd0; RegWrite = 1'b0;
        MemWrite = 1'b0; MemtoReg = 1'b0; Branch = 1'b0; BranchTaken = 1'b0;
        MemAck = 1'b0;

        @(negedge Clk);
        chk("reset:outs", {23'd0, obs()}, 32'd0);
        chk("reset:cnt", {16'd0, InstrCount}, 32'd0);
        #2 Reset = 1'b1;
        @(posedge Clk); #1;
        rest_cycle(0, 0, 0, "idle");
        rest_cycle(0, 0, 1, "idle_start");

        // Three adds then halt.
        for (int i = 0; i < 3; i++) run_instr(3'b000, 1, 0, 0, 0, 0, 0, res, "add");
        run_instr(3'b111, 0, 0, 0, 0, 0, 0, res, "halt");
        rest_cycle(1, 0, 0, "halted");
        rest_cycle(1, 0, 1, "halt_restart");

        // Memory and branch cases.
        run_instr(3'b010, 1, 0, 1, 0, 0, 3, res, "load_d3");
        run_instr(3'b011, 0, 1, 0, 0, 0, 0, res, "store_d0");
        run_instr(3'b101, 1, 1, 1, 0, 0, 2, res, "both_store");
        run_instr(3'b100, 0, 0, 0, 1, 1, 0, res, "br_taken");
        run_instr(3'b100, 0, 0, 0, 1, 0, 0, res, "br_not");
        run_instr(3'b010, 1, 0, 1, 0, 0, 99, res, "noack");
        rest_cycle(0, 1, 0, "faulted");
        rest_cycle(0, 1, 0, "faulted2");
        rest_cycle(0, 1, 1, "fault_restart");
        run_instr(3'b010, 1, 0, 1, 0, 0, 14, res, "ack_last");
        run_instr(3'b000, 1, 0, 0, 0, 0, 0, res, "after_last");

        // Enough back-to-back instructions to wrap the narrow counter.
        for (int i = 0; i < 20; i++) run_instr(3'b001, 1, 0, 0, 0, 0, 0, res, "wrap");

        // Randomized instruction stream.
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'b111 && $urandom_range(0, 1) == 1) op = 3'b000;
            run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 16)), res, "rnd");
            if (res != 0) begin
                for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                    rest_cycle(res == 1, res == 2, 0, "rnd_rest");
                rest_cycle(res == 1, res == 2, 1, "rnd_restart");
            end
        end

        // Reset asserted while a memory request is outstanding.
        Opcode = 3'b010; RegWrite = 1'b1; MemWrite = 1'b0; MemtoReg = 1'b1;
        Branch = 1'b0; BranchTaken = 1'b0; Start = 1'b0; MemAck = 1'b0;
        cyc(mk(1, 0, 0, 0, 0, 0, 1, 0, 0), "rstmem:fetch");
        cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "rstmem:decode");
        cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "rstmem:exec");
        @(negedge Clk);
        chk("rstmem:memreq", {31'd0, MemReq}, 32'd1);
        #2 Reset = 1'b0;
        exp_cnt = 0;
        #1;
        chk("rstmem:outs", {23'd0, obs()}, 32'd0);
        chk("rstmem:cnt", {16'd0, InstrCount}, 32'd0);
        @(posedge Clk); #3 Reset = 1'b1;
        @(posedge Clk); #1;
        rest_cycle(0, 0, 0, "post_rst");
        rest_cycle(0, 0, 0, "post_rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
